button_event_arbiter: RTL and testbench
=======================================

# button_event_arbiter

Collects debounced button levels from the per-button debounce instances, turns rising edges into pending events and serves them one at a time, round-robin, over a valid/ready command port. Sits between the debounce bank and the clock/programming control FSM, so that FSM sees one ordered event stream instead of NBTN asynchronous levels. Optional auto-repeat for held buttons.

## Interface
- NBTN, 5, number of buttons / width of db_level
- IDW, 3, event index width, ceil(log2(NBTN))
- REP_DELAY_CYC, 50_000_000, hold time before first repeat (500 ms at 100 MHz); used only with repeat compiled in
- REP_PERIOD_CYC, 20_000_000, interval between repeats (200 ms); used only with repeat compiled in
- reloj  in  1  system clock, 100 MHz
- resetM  in  1  reset, asynchronous, active-high
- db_level  in  NBTN  debounced button levels
- enable  in  1  0: ignore new edges, clear pending bits
- ev_ready  in  1  consumer accepts event
- clr_ovf  in  1  clears overflow
- ev_valid  out  1  event offered
- ev_id  out  IDW  button index of offered event
- ev_repeat  out  1  offered event is an auto-repeat
- pend  out  NBTN  pending bits
- overflow  out  1  sticky: an event was merged into an already pending one

## Operation
- Reset values: ev_valid 0, ev_id 0, ev_repeat 0, pend 0, overflow 0, lvl_q 0, ptr NBTN-1, state IDLE, prime 1.
- Edge detect: lvl_q <= db_level every cycle; rise = db_level & ~lvl_q. First cycle after reset (prime=1) only loads lvl_q, no rises, so buttons held through reset generate nothing.
- Pending: rise[i] & enable sets pend[i]; accepted offer of i clears it; set wins over clear in the same cycle. rise[i] while pend[i] already set and not being cleared -> overflow <= 1, event merged. clr_ovf clears overflow; a simultaneous new overflow wins.
- enable=0: pend <= 0, rises dropped, lvl_q keeps tracking. An offer in progress is held until accepted.
- FSM, two states:
  - IDLE: if any pend, pick first set index scanning ptr+1, ptr+2, … modulo NBTN; latch ev_id, ev_repeat = rep_flag[id]; ev_valid <= 1; go OFFER.
  - OFFER: ev_valid, ev_id, ev_repeat stable. On ev_ready: clear pend[ev_id] and rep_flag[ev_id], ptr <= ev_id, ev_valid <= 0, go IDLE.
- ev_valid never drops without ev_ready.

## Timing
- db_level high before edge k -> pend set at edge k -> ev_valid high after edge k+1 (2 cycles).
- Accept at edge a -> next offer no earlier than edge a+1; max throughput one event per 2 cycles.
- resetM asserted mid-offer: all outputs return to reset values immediately (asynchronous); event lost.

## Configuration
- BTN_REPEAT_EN defined: one repeat timer, width ceil(log2(max(REP_DELAY_CYC,REP_PERIOD_CYC)+1)). On accept of id, timer targets id and loads REP_DELAY_CYC. While db_level[target]=1 it counts down; at 0 it sets pend[target] and rep_flag[target] (no overflow if already pending; the repeat is simply skipped) and reloads REP_PERIOD_CYC. Release of target, enable=0, or accept of another id stops or retargets the timer.
- Not defined: no timer, rep_flag absent, ev_repeat tied 0, REP_* parameters unused.

## Structure
- Shared package btn_pkg: state localparams IDLE=1'b0, OFFER=1'b1; NBTN default; button indices BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_PROG=4.
- One sub-module: rr_pick (combinational round-robin first-set search over pend from ptr+1, returns index and any-flag).

## Test plan
- Reset release with db_level=5'b00001 held -> no ev_valid for 20 cycles; pend=0.
- Rise on bit 2, ev_ready=1 -> ev_valid 2 cycles later, ev_id=2, ev_repeat=0; pend[2]=0 after accept.
- Rise on bits 0 and 3 together, ev_ready=0 for 10 cycles -> ev_id=0 stable, then accept; then id 3. Next, simultaneous rise on 1 and 4 -> id 4 first, then 1.
- Rise on 1, ev_ready=0, release and re-press 1 -> overflow=1, single event id 1; clr_ovf pulse -> overflow=0.
- Rise on 2 landing in the accept cycle of id 2 -> second id-2 event offered, overflow stays 0.
- BTN_REPEAT_EN, REP_DELAY_CYC=8, REP_PERIOD_CYC=4, hold bit 0, ev_ready=1 -> first event ev_repeat=0; repeat events ev_repeat=1, first 8 cycles after accept, then every 4 cycles; release -> no further events.

Source files
------------

// File: rtl/button_event_arbiter_pkg.sv
// Shared constants for the button event path: FSM states, default button count, button indices.
// No logic, no latency.
// No flow control.
package btn_pkg;

    localparam int NBTN_DEFAULT = 5;
    localparam int IDW_DEFAULT  = 3;

    // Two-state offer FSM; encodings are fixed so other blocks can decode them.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_PROG  = 4;

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event command port: one button event offered at a time with valid/ready.
// No logic, no latency.
// Offer is held by the master until the slave raises ev_ready.
interface button_event_arbiter_if
    import btn_pkg::*;
#(
    parameter int IDW = IDW_DEFAULT
);
    logic           ev_valid;
    logic           ev_ready;
    logic [IDW-1:0] ev_id;
    logic           ev_repeat;

    modport master (output ev_valid, output ev_id, output ev_repeat, input ev_ready);
    modport slave  (input ev_valid, input ev_id, input ev_repeat, output ev_ready);
endinterface

// File: rtl/button_event_arbiter_rr_pick.sv
// Round-robin pick: first set bit of pend scanning ptr+1, ptr+2, ... modulo NBTN.
// Purely combinational, zero latency.
// No flow control; any is low when nothing is pending.
module rr_pick
    import btn_pkg::*;
#(
    parameter int NBTN = NBTN_DEFAULT,
    parameter int IDW  = IDW_DEFAULT
)(
    input  logic [NBTN-1:0] pend,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  id,
    output logic            any
);

    // Walk the ring starting just after the last served index; first hit wins.
    always_comb begin
        id  = '0;
        any = 1'b0;
        for (int k = 1; k <= NBTN; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NBTN;
            if (!any && pend[idx]) begin
                any = 1'b1;
                id  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Turns debounced button rising edges into pending events served round-robin on a valid/ready port.
// Level change to ev_valid: 2 cycles; at most one event every 2 cycles.
// Offer held stable until ev_ready; repeated edges on a pending button merge and set overflow.
// Optional auto-repeat for a held button when BTN_REPEAT_EN is defined.
module button_event_arbiter
    import btn_pkg::*;
#(
    parameter int NBTN           = NBTN_DEFAULT,
    parameter int IDW            = IDW_DEFAULT,
    parameter int REP_DELAY_CYC  = 50_000_000,
    parameter int REP_PERIOD_CYC = 20_000_000
)(
    input  logic                   reloj,
    input  logic                   resetM,
    input  logic [NBTN-1:0]        db_level,
    input  logic                   enable,
    input  logic                   clr_ovf,
    output logic [NBTN-1:0]        pend,
    output logic                   overflow,
    button_event_arbiter_if.master ev
);

    state_t          state, state_nxt;
    logic [NBTN-1:0] lvl_q;
    logic            prime;
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] clr;
    logic [NBTN-1:0] rep_set;
    logic            accept;
    logic            new_ovf;

    logic            valid_q, valid_nxt;
    logic [IDW-1:0]  id_q, id_nxt;
    logic            rep_q, rep_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;

    logic [IDW-1:0]  pick_id;
    logic            pick_any;

    assign ev.ev_valid  = valid_q;
    assign ev.ev_id     = id_q;
    assign ev.ev_repeat = rep_q;

    // The first cycle out of reset only captures levels, so buttons held through reset stay silent.
    assign rise    = prime ? '0 : (db_level & ~lvl_q);
    assign accept  = (state == OFFER) && ev.ev_ready;
    assign clr     = accept ? (NBTN'(1) << id_q) : '0;
    assign new_ovf = enable && (|(rise & pend & ~clr));

    rr_pick #(.NBTN(NBTN), .IDW(IDW)) u_pick (
        .pend (pend),
        .ptr  (ptr),
        .id   (pick_id),
        .any  (pick_any)
    );

`ifdef BTN_REPEAT_EN
    localparam int REP_MAX = (REP_DELAY_CYC > REP_PERIOD_CYC) ? REP_DELAY_CYC : REP_PERIOD_CYC;
    localparam int TW      = $clog2(REP_MAX + 1);

    logic [TW-1:0]   tmr_cnt;
    logic            tmr_act;
    logic [IDW-1:0]  tmr_tgt;
    logic [NBTN-1:0] rep_flag;
    logic            tgt_held;
    logic            tmr_fire;
    logic            tmr_load;

    assign tgt_held = db_level[tmr_tgt];
    assign tmr_fire = tmr_act && tgt_held && enable && (tmr_cnt <= TW'(1));
    // Accepting a repeat of the current target keeps the period running; anything else restarts the delay.
    assign tmr_load = accept && !(tmr_act && (tmr_tgt == id_q) && rep_q);

    // A repeat that finds its button still pending is dropped without touching overflow.
    always_comb begin
        rep_set = '0;
        if (tmr_fire && !(pend[tmr_tgt] && !clr[tmr_tgt]))
            rep_set = NBTN'(1) << tmr_tgt;
    end

    // Single repeat timer following the most recently accepted button while it stays held.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            tmr_act <= 1'b0;
            tmr_cnt <= '0;
            tmr_tgt <= '0;
        end else if (tmr_load) begin
            tmr_act <= 1'b1;
            tmr_tgt <= id_q;
            tmr_cnt <= TW'(REP_DELAY_CYC);
        end else if (tmr_act) begin
            if (!enable || !tgt_held)
                tmr_act <= 1'b0;
            else if (tmr_cnt <= TW'(1))
                tmr_cnt <= TW'(REP_PERIOD_CYC);
            else
                tmr_cnt <= tmr_cnt - TW'(1);
        end
    end

    // Marks which pending events came from the repeat timer.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM)
            rep_flag <= '0;
        else if (!enable)
            rep_flag <= '0;
        else
            rep_flag <= (rep_flag & ~clr) | rep_set;
    end
`else
    assign rep_set = '0;
`endif

    // Edge-detect history and pending set/clear; a new set wins over the accept clear.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            lvl_q <= '0;
            prime <= 1'b1;
            pend  <= '0;
        end else begin
            lvl_q <= db_level;
            prime <= 1'b0;
            if (!enable)
                pend <= '0;
            else
                pend <= (pend & ~clr) | rise | rep_set;
        end
    end

    // Sticky overflow; a fresh merge in the clearing cycle keeps it set.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM)
            overflow <= 1'b0;
        else if (new_ovf)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

    // Offer FSM state and registered outputs.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            rep_q   <= 1'b0;
            ptr     <= IDW'(NBTN - 1);
        end else begin
            state   <= state_nxt;
            valid_q <= valid_nxt;
            id_q    <= id_nxt;
            rep_q   <= rep_nxt;
            ptr     <= ptr_nxt;
        end
    end

    // Next-state: latch the round-robin winner in IDLE, hold the offer until it is accepted.
    always_comb begin
        state_nxt = state;
        valid_nxt = valid_q;
        id_nxt    = id_q;
        rep_nxt   = rep_q;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    id_nxt    = pick_id;
`ifdef BTN_REPEAT_EN
                    rep_nxt   = rep_flag[pick_id];
`else
                    rep_nxt   = 1'b0;
`endif
                    valid_nxt = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (ev.ev_ready) begin
                    ptr_nxt   = id_q;
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with hand-computed expectations.
// Inputs driven and outputs sampled on the falling edge.
// Repeat section active when BTN_REPEAT_EN is defined (delay 8, period 4).
module tb_button_event_arbiter;
    import btn_pkg::*;

    localparam int NBTN = 5;
    localparam int IDW  = 3;

    logic            reloj = 1'b0;
    logic            resetM;
    logic [NBTN-1:0] db_level;
    logic            enable;
    logic            clr_ovf;
    logic [NBTN-1:0] pend;
    logic            overflow;

    int n_vec = 0;
    int n_err = 0;

    button_event_arbiter_if #(.IDW(IDW)) ev_if ();

    button_event_arbiter #(
        .NBTN           (NBTN),
        .IDW            (IDW),
        .REP_DELAY_CYC  (8),
        .REP_PERIOD_CYC (4)
    ) dut (
        .reloj    (reloj),
        .resetM   (resetM),
        .db_level (db_level),
        .enable   (enable),
        .clr_ovf  (clr_ovf),
        .pend     (pend),
        .overflow (overflow),
        .ev       (ev_if.master)
    );

    always #5 reloj = ~reloj;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge reloj);
        resetM        = 1'b1;
        db_level      = '0;
        enable        = 1'b1;
        clr_ovf       = 1'b0;
        ev_if.ev_ready = 1'b0;
        repeat (2) @(negedge reloj);
        resetM = 1'b0;
        @(negedge reloj);
    endtask

    // Steps at least one cycle, then waits (bounded) for an offer.
    task automatic wait_valid(input string tag, output int gap);
        @(negedge reloj);
        gap = 1;
        while (!ev_if.ev_valid && gap < 40) begin
            @(negedge reloj);
            gap++;
        end
        chk(tag, ev_if.ev_valid, 1'b1);
    endtask

    task automatic take(input string tag, input int exp_id, input logic exp_rep);
        int g;
        wait_valid({tag, "_vld"}, g);
        chk({tag, "_id"}, ev_if.ev_id, exp_id);
        chk({tag, "_rep"}, ev_if.ev_repeat, exp_rep);
        ev_if.ev_ready = 1'b1;
        @(negedge reloj);
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        int cnt;
        cnt = 0;
        repeat (n) begin
            @(negedge reloj);
            if (ev_if.ev_valid) cnt++;
        end
        chk(tag, cnt, 0);
    endtask

    initial begin
        int g;
        int bad;

        // Reset values, with button 0 held through reset.
        resetM = 1'b1; db_level = 5'b00001; enable = 1'b1; clr_ovf = 1'b0; ev_if.ev_ready = 1'b0;
        repeat (2) @(negedge reloj);
        chk("rst_valid", ev_if.ev_valid, 0);
        chk("rst_id", ev_if.ev_id, 0);
        chk("rst_rep", ev_if.ev_repeat, 0);
        chk("rst_pend", pend, 0);
        chk("rst_ovf", overflow, 0);
        resetM = 1'b0;
        idle("held_thru_reset", 20);
        chk("held_pend", pend, 0);

        // Single rise on 2 with ready high: 2-cycle latency, then cleared.
        db_level = 5'b00100;
        ev_if.ev_ready = 1'b1;
        @(negedge reloj);
        chk("r2_pend_set", pend, 5'b00100);
        chk("r2_not_yet", ev_if.ev_valid, 0);
        @(negedge reloj);
        chk("r2_valid", ev_if.ev_valid, 1);
        chk("r2_id", ev_if.ev_id, 2);
        chk("r2_rep", ev_if.ev_repeat, 0);
        @(negedge reloj);
        chk("r2_drop", ev_if.ev_valid, 0);
        chk("r2_pend_clr", pend, 0);
        ev_if.ev_ready = 1'b0;
`ifndef BTN_REPEAT_EN
        idle("hold_no_repeat", 30);
`endif

        // Simultaneous 0 and 3 from ptr=4: 0 held under backpressure, then 3; then 1,4 -> 4 first.
        do_reset();
        db_level = 5'b01001;
        wait_valid("p03_vld", g);
        chk("p03_lat", g, 2);
        bad = 0;
        repeat (10) begin
            @(negedge reloj);
            if (!ev_if.ev_valid || ev_if.ev_id != 3'd0) bad++;
        end
        chk("p03_stable", bad, 0);
        take("p03_first", 0, 1'b0);
        take("p03_second", 3, 1'b0);
        db_level = 5'b11011;
        take("p14_first", 4, 1'b0);
        take("p14_second", 1, 1'b0);
        db_level = '0;

        // Re-press of a pending button merges and sets overflow.
        do_reset();
        db_level = 5'b00010;
        wait_valid("ovf_vld", g);
        db_level = '0;
        @(negedge reloj);
        db_level = 5'b00010;
        @(negedge reloj);
        chk("ovf_set", overflow, 1);
        chk("ovf_pend", pend, 5'b00010);
        take("ovf_ev", 1, 1'b0);
        db_level = '0;
        idle("ovf_single", 5);
        chk("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        @(negedge reloj);
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Rise landing on the accept edge of the same id: set wins, no overflow.
        do_reset();
        db_level = 5'b00100;
        wait_valid("sw_vld", g);
        db_level = '0;
        @(negedge reloj);
        db_level = 5'b00100;
        ev_if.ev_ready = 1'b1;
        @(negedge reloj);
        ev_if.ev_ready = 1'b0;
        chk("sw_pend", pend, 5'b00100);
        chk("sw_ovf0", overflow, 0);
        take("sw_second", 2, 1'b0);
        chk("sw_ovf_end", overflow, 0);
        db_level = '0;

        // Disable during an offer: offer held, pend cleared, new rises dropped.
        do_reset();
        db_level = 5'b01000;
        wait_valid("en_vld", g);
        enable = 1'b0;
        db_level = 5'b01010;
        @(negedge reloj);
        chk("en_pend0", pend, 0);
        chk("en_hold_vld", ev_if.ev_valid, 1);
        chk("en_hold_id", ev_if.ev_id, 3);
        take("en_take", 3, 1'b0);
        idle("en_dropped", 5);
        chk("en_pend_end", pend, 0);
        enable = 1'b1;
        db_level = '0;

        // Asynchronous reset in the middle of an offer.
        do_reset();
        db_level = 5'b10000;
        wait_valid("ar_vld", g);
        #2 resetM = 1'b1;
        #1;
        chk("ar_valid", ev_if.ev_valid, 0);
        chk("ar_id", ev_if.ev_id, 0);
        chk("ar_pend", pend, 0);
        @(negedge reloj);
        resetM = 1'b0;
        db_level = '0;

`ifdef BTN_REPEAT_EN
        // Held button 0 with ready high: first normal, then repeats 10 then every 4 samples.
        do_reset();
        ev_if.ev_ready = 1'b1;
        db_level = 5'b00001;
        wait_valid("rp0_vld", g);
        chk("rp0_gap", g, 2);
        chk("rp0_rep", ev_if.ev_repeat, 0);
        wait_valid("rp1_vld", g);
        chk("rp1_gap", g, 10);
        chk("rp1_rep", ev_if.ev_repeat, 1);
        wait_valid("rp2_vld", g);
        chk("rp2_gap", g, 4);
        chk("rp2_rep", ev_if.ev_repeat, 1);
        wait_valid("rp3_vld", g);
        chk("rp3_gap", g, 4);
        chk("rp3_id", ev_if.ev_id, 0);
        db_level = '0;
        idle("rp_release", 20);
        ev_if.ev_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
